uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
Byte buffer and launch controller upstream of the UART TX FSM/serializer. It accepts bytes from the system side into a small synchronous FIFO. It presents one byte at a time on TX_P_DATA with a one-cycle TX_Data_Valid pulse, and holds that byte stable for the whole frame. It then uses the TX FSM's registered Busy flag to know when the frame has started and when it has finished.

Parameters:
DATA_WIDTH, 8, width of each byte / TX_P_DATA
DEPTH, 8, FIFO entries (power of two)
ADDR_WIDTH, 3, log2(DEPTH)
BUSY_TIMEOUT, 4, max cycles to wait for TX_Busy to rise after a launch

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
WR_EN  input  1  push WR_DATA into FIFO
WR_DATA  input  DATA_WIDTH  byte to queue
FULL  output  1  FIFO holds DEPTH entries
EMPTY  output  1  FIFO holds 0 entries
COUNT  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
OVERFLOW  output  1  sticky: write attempted while FULL
LAUNCH_ERR  output  1  sticky: TX_Busy failed to rise within BUSY_TIMEOUT
TX_Busy  input  1  Busy from UART TX FSM (registered there)
TX_P_DATA  output  DATA_WIDTH  byte presented to serializer
TX_Data_Valid  output  1  one-cycle launch pulse to TX FSM

Behaviour:
- Clocking and reset: one clock CLK. Reset RST is synchronous and active-high. All state and outputs are registered.
- Reset values: rd_ptr=0, wr_ptr=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, LAUNCH_ERR=0, TX_P_DATA=0, TX_Data_Valid=0, state=IDLE, timeout counter=0.
- Reset mid-frame: applies immediately and discards both the FIFO contents and the held byte. TX_Data_Valid drops to 0 on the next edge.
- FIFO push: WR_EN=1 and FULL=0 writes mem[wr_ptr]. wr_ptr increments and wraps modulo DEPTH.
- FIFO overflow: WR_EN=1 with FULL=1 drops the byte and sets OVERFLOW. Pointers and COUNT do not change.
- FIFO pop: happens only at the launch edge (IDLE->VALID). rd_ptr increments modulo DEPTH.
- Simultaneous push and pop in one cycle: both are performed and COUNT is unchanged. A push is never accepted while FULL, even if a pop occurs in the same cycle.
- Flags: EMPTY = (COUNT==0). FULL = (COUNT==DEPTH). Both are registered, updated on the same edge as COUNT.
- Controller states:
  - IDLE: if EMPTY=0 and TX_Busy=0, then at the next edge load TX_P_DATA<=mem[rd_ptr], pop, set TX_Data_Valid<=1, and go to VALID. Otherwise stay in IDLE.
  - VALID: lasts exactly one cycle, with TX_Data_Valid=1. Next edge sets TX_Data_Valid<=0, clears the timeout counter, and goes to WAIT_BUSY.
  - WAIT_BUSY: if TX_Busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with TX_Busy still 0, set LAUNCH_ERR and go to IDLE. The held byte is dropped and not retried.
  - WAIT_DONE: stay while TX_Busy=1. On TX_Busy=0, go to IDLE.
- TX_P_DATA is held constant from the launch edge until the next launch edge. It changes only at IDLE->VALID.
- Latency: WR_EN into an empty FIFO while idle in cycle n gives COUNT=1 in cycle n+1 and TX_Data_Valid=1 in cycle n+2.
  - With the TX FSM attached, TX_Busy rises in cycle n+4 and the feeder enters WAIT_DONE in cycle n+5.
- Frame gap: the earliest next launch pulse is 2 cycles after TX_Busy falls (one cycle in IDLE, then the pulse).
- The feeder never pulses TX_Data_Valid while TX_Busy=1. Back-to-back chaining through the TX stop state is therefore not used.
- TX_Busy rising while in IDLE (spurious): ignored, and no launch occurs until it falls.
- Sticky flags OVERFLOW and LAUNCH_ERR clear only on RST.

Test Plan:
1. Single byte: reset, then WR_EN with 0xA5 in cycle 0 -> COUNT=1 in cycle 1, TX_Data_Valid=1 with TX_P_DATA=0xA5 in cycle 2 only. TX_P_DATA stays 0xA5 through Busy high/low. COUNT returns to 0.
2. Burst of 3 bytes 0x11, 0x22, 0x33 with a Busy model of 12 cycles per frame -> three pulses in that order, each only after TX_Busy=0. No pulse while TX_Busy=1. Gap from Busy fall to the next pulse is exactly 2 cycles.
3. Fill and overflow: 8 writes while TX_Busy is held 1 -> FULL=1, COUNT=8. A 9th write (0xFF) sets OVERFLOW=1 and COUNT stays 8. After release, exactly 8 bytes are launched and 0xFF never appears.
4. Wrap-around: 20 sequential bytes 0x00..0x13 with interleaved pushes and pops -> launch order exactly matches write order. COUNT is unchanged on cycles with both a push and a pop.
5. Timeout: the Busy model never rises after a pulse -> LAUNCH_ERR=1 four cycles after VALID. State returns to IDLE and the next queued byte launches.
6. Reset mid-frame: RST in WAIT_DONE with 2 bytes queued -> next cycle COUNT=0, EMPTY=1, TX_Data_Valid=0, TX_P_DATA=0, flags 0. No launch follows.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Small synchronous FIFO holding bytes for the UART TX feeder.
// Latency: a push is visible in count/empty/full on the next edge; head_dat is mem[rd_ptr] combinationally.
// Backpressure: push is ignored while full; pop is ignored while empty.
module uart_tx_feeder_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_dat,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;
    logic [ADDR_WIDTH:0]   count_nxt;

    // Qualify requests against the registered flags and work out the next occupancy.
    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !empty;
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage array; no reset needed since only slots behind wr_ptr are ever read.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; flags track count_nxt.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_CNT);
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// Byte buffer and launch controller feeding the UART TX FSM one byte per frame.
// Latency: write into empty idle FIFO in cycle n -> COUNT=1 in n+1, TX_Data_Valid pulse in n+2.
// Backpressure: writes while FULL are dropped (sticky OVERFLOW); launches wait for TX_Busy=0.
module uart_tx_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  LAUNCH_ERR,
    input  logic                  TX_Busy,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_Data_Valid
);
    // Counter needs to reach BUSY_TIMEOUT-1; BUSY_TIMEOUT must be at least 2.
    localparam int           TW       = $clog2(BUSY_TIMEOUT) + 1;
    // WAIT_BUSY gives up on the cycle whose increment would land on BUSY_TIMEOUT-1.
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        VALID     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  launch;
    logic                  tmo_expire;
    logic [TW-1:0]         tmo_cnt;
    logic [DATA_WIDTH-1:0] head_dat;

    uart_tx_feeder_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (WR_EN),
        .push_dat (WR_DATA),
        .pop      (launch),
        .head_dat (head_dat),
        .count    (COUNT),
        .full     (FULL),
        .empty    (EMPTY)
    );

    // Controller state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; launch pops the FIFO and timeout expiry drops the held byte.
    always_comb begin
        state_nxt  = state;
        launch     = 1'b0;
        tmo_expire = 1'b0;
        case (state)
            IDLE: begin
                // A busy serializer (even a spurious one) blocks any launch.
                if (!EMPTY && !TX_Busy) begin
                    launch    = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TX_Busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_expire = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!TX_Busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs: launch pulse, held byte, timeout counter and sticky error flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            TX_Data_Valid <= 1'b0;
            TX_P_DATA     <= '0;
            tmo_cnt       <= '0;
            OVERFLOW      <= 1'b0;
            LAUNCH_ERR    <= 1'b0;
        end else begin
            TX_Data_Valid <= launch;
            // The byte is held for the whole frame and only replaced by the next launch.
            if (launch) begin
                TX_P_DATA <= head_dat;
            end
            if (state == VALID) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_BUSY && !TX_Busy) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_expire) begin
                LAUNCH_ERR <= 1'b1;
            end
            if (WR_EN && FULL) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed stimulus, TX FSM busy model, scoreboard monitor.
// Launch checks are decoupled from stimulus through an expected-byte queue.
// All waits are bounded by cycle budgets and a global watchdog.
module tb_uart_tx_feeder;

    logic       CLK;
    logic       RST;
    logic       WR_EN;
    logic [7:0] WR_DATA;
    logic       FULL;
    logic       EMPTY;
    logic [3:0] COUNT;
    logic       OVERFLOW;
    logic       LAUNCH_ERR;
    logic       TX_Busy;
    logic [7:0] TX_P_DATA;
    logic       TX_Data_Valid;

    uart_tx_feeder #(
        .DATA_WIDTH   (8),
        .DEPTH        (8),
        .ADDR_WIDTH   (3),
        .BUSY_TIMEOUT (4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .WR_EN         (WR_EN),
        .WR_DATA       (WR_DATA),
        .FULL          (FULL),
        .EMPTY         (EMPTY),
        .COUNT         (COUNT),
        .OVERFLOW      (OVERFLOW),
        .LAUNCH_ERR    (LAUNCH_ERR),
        .TX_Busy       (TX_Busy),
        .TX_P_DATA     (TX_P_DATA),
        .TX_Data_Valid (TX_Data_Valid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Busy model: 0 = normal frames, 1 = never rises, 2 = forced high
    int bm_mode  = 0;
    int bm_frame = 12;
    int bm_dly   = 0;
    int bm_left  = 0;

    // Scoreboard / monitor state
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    logic [7:0] held = 8'h00;
    logic       prev_busy = 1'b0;
    logic       prev_rst  = 1'b1;
    int n_pulses       = 0;
    int fall_cyc       = -1;
    int last_pulse_cyc = -1;
    int gap_chk        = 0;
    int gap_seen       = 0;

    logic [7:0] t2 [3] = '{8'h11, 8'h22, 8'h33};
    int base;
    int pushed;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs are driven and outputs sampled mid-cycle, after the busy model and monitor.
    task automatic step();
        @(negedge CLK);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_pulses < target && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(n_pulses), 32'(target));
    endtask

    // TX FSM stand-in: Busy rises two cycles after a launch pulse and stays up bm_frame cycles.
    initial begin
        TX_Busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                bm_dly  = 0;
                bm_left = 0;
            end else begin
                if (bm_left > 0) bm_left--;
                if (bm_dly > 0) begin
                    bm_dly--;
                    if (bm_dly == 0) bm_left = bm_frame;
                end
                if (TX_Data_Valid && bm_mode == 0) bm_dly = 2;
            end
            TX_Busy = (bm_mode == 2) || (bm_left > 0);
        end
    end

    // Monitor: checks every launch against the scoreboard, the frame gap and byte hold.
    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (RST) begin
                prev_rst = 1'b1;
            end else begin
                if (prev_rst) held = 8'h00;
                prev_rst = 1'b0;
                if (prev_busy && !TX_Busy) fall_cyc = cyc;
                if (TX_Data_Valid) begin
                    n_pulses++;
                    chk("mon_no_pulse_while_busy", 32'(TX_Busy), 0);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL mon_unexpected_launch: got 0x%0h, expected no launch (cycle %0d)",
                                 TX_P_DATA, cyc);
                    end else begin
                        exp_b = exp_q.pop_front();
                        chk("mon_launch_data", 32'(TX_P_DATA), 32'(exp_b));
                    end
                    if (gap_chk != 0 && fall_cyc > last_pulse_cyc) begin
                        gap_seen++;
                        chk("mon_frame_gap", 32'(cyc - fall_cyc), 2);
                    end
                    last_pulse_cyc = cyc;
                    held = TX_P_DATA;
                end else begin
                    chk("mon_hold", 32'(TX_P_DATA), 32'(held));
                end
            end
            prev_busy = TX_Busy;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST     = 1'b1;
        WR_EN   = 1'b0;
        WR_DATA = 8'h00;
        idle(3);
        chk("rst_count",      32'(COUNT), 0);
        chk("rst_empty",      32'(EMPTY), 1);
        chk("rst_full",       32'(FULL), 0);
        chk("rst_overflow",   32'(OVERFLOW), 0);
        chk("rst_launch_err", 32'(LAUNCH_ERR), 0);
        chk("rst_data",       32'(TX_P_DATA), 0);
        chk("rst_valid",      32'(TX_Data_Valid), 0);
        RST = 1'b0;

        // 1: single byte latency and hold
        step();
        WR_EN = 1'b1; WR_DATA = 8'hA5; exp_q.push_back(8'hA5);
        step();
        WR_EN = 1'b0;
        chk("t1_count_n1", 32'(COUNT), 1);
        chk("t1_valid_n1", 32'(TX_Data_Valid), 0);
        step();
        chk("t1_valid_n2", 32'(TX_Data_Valid), 1);
        chk("t1_data_n2",  32'(TX_P_DATA), 'hA5);
        chk("t1_count_n2", 32'(COUNT), 0);
        step();
        chk("t1_valid_n3", 32'(TX_Data_Valid), 0);
        idle(30);
        chk("t1_data_held", 32'(TX_P_DATA), 'hA5);
        chk("t1_empty",     32'(EMPTY), 1);

        // 2: burst of three, 12-cycle frames, exact 2-cycle gap after Busy falls
        base = n_pulses;
        for (int i = 0; i < 3; i++) begin
            step();
            WR_EN = 1'b1; WR_DATA = t2[i]; exp_q.push_back(t2[i]);
        end
        step();
        WR_EN = 1'b0;
        wait_pulses(base + 1, 20, "t2_first_launch");
        gap_chk = 1;
        wait_pulses(base + 3, 80, "t2_all_launched");
        idle(20);
        gap_chk = 0;
        chk("t2_gaps_checked", 32'(gap_seen), 2);

        // 3: fill while Busy forced high, overflow, then drain
        bm_mode = 2;
        idle(2);
        base = n_pulses;
        for (int i = 0; i < 8; i++) begin
            step();
            WR_EN = 1'b1; WR_DATA = 8'(8'h80 + i); exp_q.push_back(8'(8'h80 + i));
        end
        step();
        WR_DATA = 8'hFF;
        chk("t3_full",         32'(FULL), 1);
        chk("t3_count_full",   32'(COUNT), 8);
        chk("t3_ovf_before",   32'(OVERFLOW), 0);
        chk("t3_no_launch",    32'(n_pulses), 32'(base));
        step();
        WR_EN = 1'b0;
        chk("t3_overflow",     32'(OVERFLOW), 1);
        chk("t3_count_held",   32'(COUNT), 8);
        chk("t3_full_held",    32'(FULL), 1);
        bm_mode = 0;
        wait_pulses(base + 8, 200, "t3_drained");
        idle(20);
        chk("t3_count_end",    32'(COUNT), 0);
        chk("t3_empty_end",    32'(EMPTY), 1);
        chk("t3_ovf_sticky",   32'(OVERFLOW), 1);

        // 4: 20 bytes with interleaved push/pop, COUNT tracked every cycle
        bm_frame = 2;
        base   = n_pulses;
        pushed = 0;
        for (int c = 0; c < 140; c++) begin
            step();
            chk("t4_count", 32'(COUNT), 32'(pushed - (n_pulses - base)));
            if (c % 5 == 0 && pushed < 20) begin
                WR_EN = 1'b1; WR_DATA = 8'(pushed); exp_q.push_back(8'(pushed));
                pushed++;
            end else begin
                WR_EN = 1'b0;
            end
        end
        WR_EN = 1'b0;
        wait_pulses(base + 20, 60, "t4_all_launched");
        idle(10);
        chk("t4_no_launch_err", 32'(LAUNCH_ERR), 0);

        // 5: Busy never rises for the first byte -> timeout, then the next byte launches
        bm_frame = 4;
        bm_mode  = 1;
        base     = n_pulses;
        step();
        WR_EN = 1'b1; WR_DATA = 8'h55; exp_q.push_back(8'h55);
        step();
        WR_DATA = 8'h66; exp_q.push_back(8'h66);
        step();
        WR_EN = 1'b0;
        wait_pulses(base + 1, 10, "t5_first_launch");
        bm_mode = 0;
        idle(3);
        chk("t5_err_v3", 32'(LAUNCH_ERR), 0);
        step();
        chk("t5_err_v4", 32'(LAUNCH_ERR), 1);
        step();
        chk("t5_relaunch_valid", 32'(TX_Data_Valid), 1);
        chk("t5_relaunch_data",  32'(TX_P_DATA), 'h66);
        idle(20);
        chk("t5_err_sticky", 32'(LAUNCH_ERR), 1);

        // 6: reset in WAIT_DONE with two bytes still queued
        bm_frame = 20;
        base     = n_pulses;
        step();
        WR_EN = 1'b1; WR_DATA = 8'h77; exp_q.push_back(8'h77);
        step();
        WR_DATA = 8'h88;
        step();
        WR_DATA = 8'h99;
        step();
        WR_EN = 1'b0;
        wait_pulses(base + 1, 10, "t6_first_launch");
        idle(3);
        chk("t6_count_before", 32'(COUNT), 2);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("t6_count",      32'(COUNT), 0);
        chk("t6_empty",      32'(EMPTY), 1);
        chk("t6_full",       32'(FULL), 0);
        chk("t6_valid",      32'(TX_Data_Valid), 0);
        chk("t6_data",       32'(TX_P_DATA), 0);
        chk("t6_overflow",   32'(OVERFLOW), 0);
        chk("t6_launch_err", 32'(LAUNCH_ERR), 0);
        idle(40);
        chk("t6_no_launch",  32'(n_pulses), 32'(base + 1));

        chk("end_scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
